// File: rtl/writeback_arbiter_if.sv
// Request-side bus between the four functional units and the writeback arbiter.
// master: a functional unit presenting results; slave: the arbiter granting them.
interface writeback_arbiter_if #(
    parameter int unsigned DATABITWIDTH    = 16,
    parameter int unsigned REGADDRBITWIDTH = 4,
    parameter int unsigned TAGBITWIDTH     = 6
);
    logic [3:0]                   Req_Valid;
    logic [3:0]                   Req_Ready;
    logic [4*DATABITWIDTH-1:0]    Req_Data;
    logic [4*REGADDRBITWIDTH-1:0] Req_Addr;
    logic [4*TAGBITWIDTH-1:0]     Req_Tag;

    modport master (
        output Req_Valid,
        output Req_Data,
        output Req_Addr,
        output Req_Tag,
        input  Req_Ready
    );

    modport slave (
        input  Req_Valid,
        input  Req_Data,
        input  Req_Addr,
        input  Req_Tag,
        output Req_Ready
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port among ALU0, ALU1, Branch and LSU,
// with a registered congestion stall. Define WRITEBACK_R0_DISCARD_EN to retire r0 writes only.
module writeback_arbiter #(
    parameter int unsigned DATABITWIDTH    = 16,
    parameter int unsigned REGADDRBITWIDTH = 4,
    parameter int unsigned TAGBITWIDTH     = 6,
    parameter int unsigned STALLTHRESHOLD  = 3
) (
    input  logic                       clk,
    input  logic                       clk_en,
    input  logic                       sync_rst,
    writeback_arbiter_if.slave         req,
    output logic                       RegWriteEn,
    output logic [REGADDRBITWIDTH-1:0] RegWriteAddr,
    output logic [DATABITWIDTH-1:0]    RegWriteData,
    output logic [TAGBITWIDTH-1:0]     RegWriteTag,
    output logic                       IssueCongestionStallOut
`ifdef WRITEBACK_R0_DISCARD_EN
    ,
    output logic                       RetireOnly
`endif
);

    logic [1:0] ptr_q;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic [3:0] grant;
    logic       xfer;
    logic [3:0] wait_q [4];
    logic [3:0] wait_d [4];
    logic       stall_d;

    logic [DATABITWIDTH-1:0]    win_data;
    logic [REGADDRBITWIDTH-1:0] win_addr;
    logic [TAGBITWIDTH-1:0]     win_tag;

    // First valid unit at or after ptr_q (mod 4) wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req.Req_Valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        grant = '0;
        if (found && clk_en && !sync_rst) begin
            grant[win] = 1'b1;
        end
    end

    assign req.Req_Ready = grant;
    assign xfer          = |grant;

    assign win_data = req.Req_Data[32'(win)*DATABITWIDTH +: DATABITWIDTH];
    assign win_addr = req.Req_Addr[32'(win)*REGADDRBITWIDTH +: REGADDRBITWIDTH];
    assign win_tag  = req.Req_Tag[32'(win)*TAGBITWIDTH +: TAGBITWIDTH];

    always_comb begin
        stall_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_d[i] = '0;
            if (req.Req_Valid[i] && !grant[i]) begin
                wait_d[i] = (wait_q[i] == 4'hF) ? 4'hF : wait_q[i] + 4'd1;
            end
            if (wait_d[i] >= 4'(STALLTHRESHOLD)) begin
                stall_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            ptr_q                   <= '0;
            wait_q                  <= '{default: '0};
            RegWriteEn              <= 1'b0;
            RegWriteAddr            <= '0;
            RegWriteData            <= '0;
            RegWriteTag             <= '0;
            IssueCongestionStallOut <= 1'b0;
`ifdef WRITEBACK_R0_DISCARD_EN
            RetireOnly              <= 1'b0;
`endif
        end else if (clk_en) begin
            wait_q                  <= wait_d;
            IssueCongestionStallOut <= stall_d;
`ifdef WRITEBACK_R0_DISCARD_EN
            // r0 results retire their tag without touching the register file.
            RegWriteEn              <= xfer && (win_addr != '0);
            RetireOnly              <= xfer && (win_addr == '0);
`else
            RegWriteEn              <= xfer;
`endif
            if (xfer) begin
                ptr_q        <= win + 2'd1;
                RegWriteAddr <= win_addr;
                RegWriteData <= win_data;
                RegWriteTag  <= win_tag;
            end
        end
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Shares the single register-file write port between four functional units: ALU0, ALU1, Branch/PC link, and Load-Store.
- Each unit presents a completed result with a valid/ready handshake.
- The arbiter grants one unit per cycle using round-robin priority and registers the winner onto the write port.
- It raises a congestion stall toward issue when any unit waits too long. This stall is the source for the issue stage's congestion-stall input.

Parameters:
- DATABITWIDTH, 16, result data width
- REGADDRBITWIDTH, 4, register address width
- TAGBITWIDTH, 6, instruction tag width
- STALLTHRESHOLD, 3, wait cycles (1-15) at which congestion stall asserts

Ports:
- clk  in  1  clock
- clk_en  in  1  global clock enable; low = freeze all state
- sync_rst  in  1  synchronous active-high reset
- Req_Valid  in  4  per-unit result valid; bit0 ALU0, bit1 ALU1, bit2 Branch, bit3 LSU
- Req_Ready  out  4  per-unit grant (one-hot or zero), combinational
- Req_Data  in  4*DATABITWIDTH  per-unit result; unit i at [i*DATABITWIDTH +: DATABITWIDTH]
- Req_Addr  in  4*REGADDRBITWIDTH  per-unit destination register
- Req_Tag  in  4*TAGBITWIDTH  per-unit instruction tag
- RegWriteEn  out  1  register-file write strobe
- RegWriteAddr  out  REGADDRBITWIDTH  write address
- RegWriteData  out  DATABITWIDTH  write data
- RegWriteTag  out  TAGBITWIDTH  tag of retiring instruction, used for scoreboard release
- IssueCongestionStallOut  out  1  stall request to issue stage

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high (sync_rst). Ports are named clk / clk_en / sync_rst.
  - Reset values: RegWriteEn=0, RegWriteAddr=0, RegWriteData=0, RegWriteTag=0, IssueCongestionStallOut=0.
  - Reset also clears the round-robin pointer Ptr to 0 and all wait counters to 0.
  - Req_Ready=0 while sync_rst=1 or clk_en=0.
- Handshake:
  - Transfer for unit i occurs when Req_Valid[i] & Req_Ready[i].
  - Once Req_Valid[i] rises, the unit holds Valid, Data, Addr and Tag stable until its transfer. Valid deasserting without a transfer is a protocol error (bench assertion).
- Arbitration (combinational):
  - Search Req_Valid starting at index Ptr, ascending mod 4. The first set bit wins and its Req_Ready bit is driven high.
  - If no Req_Valid bits are set, Req_Ready=0.
- Pointer update (clk_en=1):
  - On a transfer from unit g, Ptr <= (g+1) mod 4.
  - With no transfer, Ptr holds.
- Write port (1-cycle latency, registered):
  - Transfer in cycle N: in cycle N+1, RegWriteEn=1 and Addr/Data/Tag equal the winner's values.
  - No transfer: RegWriteEn <= 0. Addr/Data/Tag hold their last values.
  - Back-to-back transfers give a continuous write stream at 1 write/cycle.
- Wait counters (one 4-bit saturating counter Wait[i] per unit, clk_en=1):
  - Valid[i] & ~Ready[i]: increment, saturating at 15.
  - Transfer or ~Valid[i]: clear to 0.
- Congestion stall:
  - IssueCongestionStallOut <= OR over i of (Wait_next[i] >= STALLTHRESHOLD). This is registered and asserts the cycle after the threshold is reached.
  - It deasserts one cycle after every counter drops below threshold.
- clk_en=0: all registers hold, including RegWriteEn. The register file is gated by the same enable, so no duplicate write occurs.
- Reset mid-operation: all pending requests are ignored for that cycle and no Ready is issued. Units keep Valid asserted and are re-arbitrated starting from Ptr=0 after reset.
- Starvation bound: a continuously valid unit is granted within 4 cycles.

Optional Feature:
- Macro: WRITEBACK_R0_DISCARD_EN.
- Defined: a transfer whose Req_Addr==0 is still granted and Ptr still advances, but RegWriteEn stays 0 the next cycle. RegWriteTag still updates, and an extra output port RetireOnly (1 bit, reset 0) pulses 1 for that cycle so the scoreboard can release the tag.
- Undefined: address 0 is written like any other register and the RetireOnly port does not exist.

Test Plan:
- Reset then single request: Req_Valid=4'b0001, Addr=5, Data=16'h1234, Tag=6'h0A -> Req_Ready=4'b0001 same cycle; next cycle RegWriteEn=1, Addr=5, Data=16'h1234, Tag=6'h0A; Ptr=1.
- All four valid held continuously from Ptr=0 -> grants 0,1,2,3 in consecutive cycles; RegWriteEn high 4 consecutive cycles with each unit's data in order.
- Units 0 and 1 both valid, unit 0 re-requests immediately after its grant -> unit 1 granted next cycle (round-robin), never more than 1 cycle skipped.
- STALLTHRESHOLD=3, clk_en pattern forcing unit 3 to wait behind units 0-2 -> IssueCongestionStallOut rises the cycle after Wait[3] reaches 3 and falls one cycle after unit 3's transfer.
- Requests pending, clk_en=0 for 5 cycles -> Req_Ready=0, outputs and Ptr frozen; arbitration resumes on the first clk_en=1 cycle.
- sync_rst pulsed while 3 units valid with Ptr=2 -> next cycle RegWriteEn=0, stall=0, Ptr=0; the first grant after reset goes to the lowest valid index. With WRITEBACK_R0_DISCARD_EN, a write to Addr=0 gives RegWriteEn=0 and RetireOnly=1.
